// File: rtl/memory_led_panel.sv
`default_nettype none
// ============================================================================
//  Module      : memory_led_panel
//  Description : Bus slave for the CPU6 byte bus combining a 2**RAM_AW-byte
//                block RAM and a write/readable 8-bit LED latch behind one
//                shared address / write-data / write-enable bus and a
//                single read-data return path.
//  Ports       : clock     - system clock, all state is posedge clocked
//                reset     - synchronous active-high reset
//                address   - 16-bit CPU byte address
//                write_en  - write data_in to the decoded target this edge
//                data_in   - 8-bit CPU-to-slave write data
//                data_out  - 8-bit slave-to-CPU read data, one-cycle latency
//                leds      - LED latch, bit 7 = LED1 ... bit 0 = LED8, 1 = lit
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_led_panel #(
    parameter logic [15:0] RAM_BASE  = 16'h0000,
    parameter int          RAM_AW    = 8,
    parameter logic [15:0] LED_ADDR  = 16'hF110,
    parameter string       INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic [7:0]  leds
);

    localparam int          c_DEPTH     = 1 << RAM_AW;
    localparam logic [16:0] c_DEPTH_17  = 17'(c_DEPTH);

    // Read-source select for the registered read path.
    localparam logic [1:0]  c_SRC_ZERO  = 2'd0;
    localparam logic [1:0]  c_SRC_RAM   = 2'd1;
    localparam logic [1:0]  c_SRC_LED   = 2'd2;

    // LED offset from RAM_BASE, computed with a spare bit so a LED_ADDR below
    // RAM_BASE shows up as negative rather than wrapping into the window.
    localparam logic [16:0] c_LED_OFF   = {1'b0, LED_ADDR} - {1'b0, RAM_BASE};

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (!c_LED_OFF[16] && (c_LED_OFF < c_DEPTH_17)) begin : g_led_in_ram
        $error("memory_led_panel: LED_ADDR lies inside the RAM window");
    end

    if ((RAM_AW < 1) || (RAM_AW > 16)) begin : g_bad_aw
        $error("memory_led_panel: RAM_AW must be in 1..16");
    end

    if (INIT_FILE != "") begin : g_init_note
        $warning("memory_led_panel: INIT_FILE preload must be applied by the memory-initialisation step of the build flow");
    end

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic [16:0]        w_off_full;
    logic [RAM_AW-1:0]  w_ram_off;
    logic               w_ram_hit;
    logic               w_led_hit;

    // Subtract with a borrow bit: an address below RAM_BASE sets bit 16 and is
    // therefore never a hit, so the window cannot alias onto low addresses.
    assign w_off_full = {1'b0, address} - {1'b0, RAM_BASE};
    assign w_ram_hit  = !w_off_full[16] && (w_off_full < c_DEPTH_17);
    assign w_ram_off  = w_off_full[RAM_AW-1:0];
    assign w_led_hit  = (address == LED_ADDR);

    // ------------------------------------------------------------------------
    // RAM array: one synchronous write port, one synchronous read port, no
    // reset on the array or the raw read register so it maps onto EBR.
    // ------------------------------------------------------------------------
    logic [7:0] r_mem [0:c_DEPTH-1];
    logic [7:0] r_ram_q;

    always_ff @(posedge clock) begin
        if (write_en && w_ram_hit && !reset) begin
            r_mem[w_ram_off] <= data_in;
        end
    end

    // Reading the array in its own block gives read-before-write: the old
    // byte is captured on the same edge that stores the new one.
    always_ff @(posedge clock) begin
        r_ram_q <= r_mem[w_ram_off];
    end

    // ------------------------------------------------------------------------
    // LED latch and read-path select
    // ------------------------------------------------------------------------
    logic [7:0] r_leds;
    logic [7:0] r_led_q;
    logic [1:0] r_src;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_leds  <= 8'h00;
            r_led_q <= 8'h00;
            r_src   <= c_SRC_ZERO;
        end else begin
            if (write_en && w_led_hit) begin
                r_leds <= data_in;
            end
            // Captures the pre-write latch value on a same-edge write+read.
            r_led_q <= r_leds;
            if (w_ram_hit) begin
                r_src <= c_SRC_RAM;
            end else if (w_led_hit) begin
                r_src <= c_SRC_LED;
            end else begin
                r_src <= c_SRC_ZERO;
            end
        end
    end

    // The unresettable RAM read register is masked by the select, which is
    // what makes data_out read zero after reset.
    logic [7:0] w_data_out;

    always_comb begin
        w_data_out = 8'h00;
        case (r_src)
            c_SRC_RAM: w_data_out = r_ram_q;
            c_SRC_LED: w_data_out = r_led_q;
            default:   w_data_out = 8'h00;
        endcase
    end

    assign data_out = w_data_out;
    assign leds     = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_memory_led_panel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_led_panel
//  Description : Self-checking bench for memory_led_panel. A byte-addressed
//                reference model (associative array plus LED byte) predicts
//                data_out and leds for every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_led_panel;

    localparam logic [15:0] c_RAM_BASE = 16'h0000;
    localparam int          c_RAM_AW   = 8;
    localparam logic [15:0] c_LED_ADDR = 16'hF110;
    localparam int          c_DEPTH    = 1 << c_RAM_AW;

    logic        clock;
    logic        reset;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [7:0]  leds;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned m_ram [int];
    byte unsigned m_leds;

    memory_led_panel #(
        .RAM_BASE  (c_RAM_BASE),
        .RAM_AW    (c_RAM_AW),
        .LED_ADDR  (c_LED_ADDR),
        .INIT_FILE ("")
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .leds     (leds)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit in_ram(input logic [15:0] a);
        int off;
        off = int'(a) - int'(c_RAM_BASE);
        return (off >= 0) && (off < c_DEPTH);
    endfunction

    // Drives one bus cycle, advances the model, waits past the edge and
    // returns what the model expects to see now. known=0 means the read hit a
    // RAM byte never written, whose contents are undefined.
    task automatic step(input logic [15:0] a, input logic we, input logic [7:0] d,
                        input logic rst, output logic [7:0] exp_d, output bit known,
                        output logic [7:0] exp_l);
        int off;
        address  = a;
        write_en = we;
        data_in  = d;
        reset    = rst;
        off      = int'(a) - int'(c_RAM_BASE);
        known    = 1'b1;
        if (rst) begin
            exp_d = 8'h00;
        end else if (in_ram(a)) begin
            if (m_ram.exists(off)) begin
                exp_d = m_ram[off];
            end else begin
                exp_d = 8'h00;
                known = 1'b0;
            end
        end else if (a == c_LED_ADDR) begin
            exp_d = m_leds;
        end else begin
            exp_d = 8'h00;
        end
        if (rst) begin
            m_leds = 8'h00;
        end else if (we) begin
            if (in_ram(a))            m_ram[off] = d;
            else if (a == c_LED_ADDR) m_leds     = d;
        end
        exp_l = m_leds;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] ed, el;
        bit k;
        for (int i = 0; i < 2; i++) begin
            step(c_LED_ADDR, 1'b1, 8'hAA, 1'b1, ed, k, el);
            checks++;
            if (leds !== 8'h00) begin
                errors++;
                $display("FAIL reset_leds: got %h expected %h", leds, 8'h00);
            end
            checks++;
            if (data_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_data_out: got %h expected %h", data_out, 8'h00);
            end
        end
    endtask

    task automatic test_ram_rw;
        logic [7:0] ed, el;
        bit k;
        step(16'h0010, 1'b1, 8'h5A, 1'b0, ed, k, el);
        step(16'h00FF, 1'b1, 8'hC3, 1'b0, ed, k, el);
        step(16'h0010, 1'b0, 8'h00, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h5A || ed !== 8'h5A) begin
            errors++;
            $display("FAIL ram_read_0010: got %h expected %h", data_out, 8'h5A);
        end
        step(16'h00FF, 1'b0, 8'h00, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'hC3) begin
            errors++;
            $display("FAIL ram_read_00ff: got %h expected %h", data_out, 8'hC3);
        end
    endtask

    task automatic test_led;
        logic [7:0] ed, el;
        bit k;
        step(c_LED_ADDR, 1'b1, 8'h81, 1'b0, ed, k, el);
        checks++;
        if (leds !== 8'h81) begin
            errors++;
            $display("FAIL led_write: got %h expected %h", leds, 8'h81);
        end
        step(c_LED_ADDR, 1'b0, 8'h00, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h81) begin
            errors++;
            $display("FAIL led_read: got %h expected %h", data_out, 8'h81);
        end
        step(16'h0010, 1'b0, 8'h00, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h5A) begin
            errors++;
            $display("FAIL led_ram_intact: got %h expected %h", data_out, 8'h5A);
        end
    endtask

    task automatic test_read_before_write;
        logic [7:0] ed, el;
        bit k;
        step(16'h0020, 1'b1, 8'h11, 1'b0, ed, k, el);
        step(16'h0020, 1'b1, 8'h22, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h11) begin
            errors++;
            $display("FAIL rbw_old: got %h expected %h", data_out, 8'h11);
        end
        step(16'h0020, 1'b0, 8'h00, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h22) begin
            errors++;
            $display("FAIL rbw_new: got %h expected %h", data_out, 8'h22);
        end
        // Same-edge write+read of the LED latch returns the pre-write value.
        step(c_LED_ADDR, 1'b1, 8'h3C, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h81 || leds !== 8'h3C) begin
            errors++;
            $display("FAIL rbw_led: got dout %h leds %h expected %h %h", data_out, leds, 8'h81, 8'h3C);
        end
    endtask

    task automatic test_unmapped;
        logic [7:0] ed, el;
        bit k;
        step(16'h8000, 1'b1, 8'h77, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h00 || leds !== 8'h3C) begin
            errors++;
            $display("FAIL unmapped_write: got dout %h leds %h expected %h %h", data_out, leds, 8'h00, 8'h3C);
        end
        step(16'h8000, 1'b0, 8'h00, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_read: got %h expected %h", data_out, 8'h00);
        end
        // 0x0100 is one past the window and must not alias onto offset 0x00.
        step(16'h0100, 1'b1, 8'h99, 1'b0, ed, k, el);
        step(16'h0000, 1'b1, 8'h44, 1'b0, ed, k, el);
        step(16'h0100, 1'b0, 8'h00, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_edge: got %h expected %h", data_out, 8'h00);
        end
        step(16'h0000, 1'b0, 8'h00, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h44) begin
            errors++;
            $display("FAIL unmapped_no_alias: got %h expected %h", data_out, 8'h44);
        end
        step(16'h0010, 1'b0, 8'h00, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h5A) begin
            errors++;
            $display("FAIL unmapped_ram_intact: got %h expected %h", data_out, 8'h5A);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] ed, el;
        bit k;
        step(c_LED_ADDR, 1'b1, 8'hF0, 1'b0, ed, k, el);
        step(16'h0005,   1'b1, 8'h33, 1'b0, ed, k, el);
        checks++;
        if (leds !== 8'hF0) begin
            errors++;
            $display("FAIL mid_leds_set: got %h expected %h", leds, 8'hF0);
        end
        step(16'h0005, 1'b1, 8'hEE, 1'b1, ed, k, el);
        checks++;
        if (leds !== 8'h00 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got leds %h dout %h expected %h %h", leds, data_out, 8'h00, 8'h00);
        end
        step(16'h0005, 1'b0, 8'h00, 1'b0, ed, k, el);
        checks++;
        if (data_out !== 8'h33) begin
            errors++;
            $display("FAIL mid_ram_kept: got %h expected %h", data_out, 8'h33);
        end
    endtask

    task automatic test_random;
        logic [7:0]  ed, el, d;
        logic [15:0] a;
        logic        we, rst;
        bit          k;
        int          sel;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       a = 16'($urandom_range(0, 255)) + c_RAM_BASE;
            else if (sel < 8)  a = c_LED_ADDR;
            else               a = 16'($urandom_range(256, 65535));
            we  = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            rst = ($urandom_range(0, 49) == 0);
            step(a, we, d, rst, ed, k, el);
            checks++;
            if (leds !== el) begin
                errors++;
                $display("FAIL rand_leds[%0d]: addr %h got %h expected %h", i, a, leds, el);
            end
            if (k) begin
                checks++;
                if (data_out !== ed) begin
                    errors++;
                    $display("FAIL rand_dout[%0d]: addr %h got %h expected %h", i, a, data_out, ed);
                end
            end
        end
    endtask

    initial begin
        m_leds   = 8'h00;
        reset    = 1'b1;
        address  = 16'h0000;
        write_en = 1'b0;
        data_in  = 8'h00;
        @(negedge clock);
        test_reset;
        test_ram_rw;
        test_led;
        test_read_before_write;
        test_unmapped;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
